// File: rtl/puc_pkg.sv
// Shared definitions for the PucCPU core: instruction layout, opcodes and
// the sequencer state encoding. The ALU imports the same package.
package puc_pkg;

  localparam int OPCODE_WIDTH   = 4;
  localparam int REGISTER_WIDTH = 8;
  localparam int REG_ADDR_WIDTH = 2;
  localparam int PC_WIDTH       = 8;
  localparam int INSTR_WIDTH    = OPCODE_WIDTH + 2*REG_ADDR_WIDTH + REGISTER_WIDTH;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  // Field offsets inside an instruction word: [opcode | rd | rs | imm]
  localparam int IMM_LSB    = 0;
  localparam int RS_LSB     = IMM_LSB + REGISTER_WIDTH;
  localparam int RD_LSB     = RS_LSB + REG_ADDR_WIDTH;
  localparam int OPCODE_LSB = RD_LSB + REG_ADDR_WIDTH;

  typedef logic [OPCODE_WIDTH-1:0]   opcode_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REGISTER_WIDTH-1:0] data_t;
  typedef logic [INSTR_WIDTH-1:0]    instr_t;

  localparam opcode_t OP_NOP        = 4'd0;
  localparam opcode_t OP_LOAD       = 4'd1;
  localparam opcode_t OP_LOADSWITCH = 4'd2;
  localparam opcode_t OP_ADD        = 4'd3;
  localparam opcode_t OP_LSHIFT     = 4'd4;
  localparam opcode_t OP_RSHIFT     = 4'd5;
  localparam opcode_t OP_INC        = 4'd6;
  localparam opcode_t OP_DECREMENT  = 4'd7;
  localparam opcode_t OP_JUMP       = 4'd8;
  localparam opcode_t OP_HALT       = 4'd15;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} seq_state_t;

  function automatic opcode_t field_op(instr_t w);
    return w[OPCODE_LSB +: OPCODE_WIDTH];
  endfunction

  function automatic reg_addr_t field_rd(instr_t w);
    return w[RD_LSB +: REG_ADDR_WIDTH];
  endfunction

  function automatic reg_addr_t field_rs(instr_t w);
    return w[RS_LSB +: REG_ADDR_WIDTH];
  endfunction

  function automatic data_t field_imm(instr_t w);
    return w[IMM_LSB +: REGISTER_WIDTH];
  endfunction

  // Opcodes whose ALU result is written back to R[rd]
  function automatic logic is_write_op(opcode_t op);
    return (op >= OP_LOAD) && (op <= OP_DECREMENT);
  endfunction

endpackage

// File: rtl/register_file.sv
// Four general-purpose registers: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear.
module register_file
  import puc_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      write_en,
  input  reg_addr_t write_addr,
  input  data_t     write_data,
  input  reg_addr_t read_addr_a,
  output data_t     read_data_a,
  input  reg_addr_t read_addr_b,
  output data_t     read_data_b,
  output data_t     r0
);

  data_t regs [NUM_REGS];

  // Clear has priority so a write racing a reset is discarded
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data_a = regs[read_addr_a];
  assign read_data_b = regs[read_addr_b];
  assign r0          = regs[0];

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/writeback sequencer for the PucCPU core. Three cycles per
// instruction, no pipelining; the ALU sits outside and returns aluResult
// combinationally from the operand outputs.
//
//   state   | meaning
//   FETCH   | instrAddr = pc presented to ROM; waits here while run = 0
//   DECODE  | ROM word arrives; latched into ir, ALU operands registered
//   EXECUTE | operands valid; write-back / pc update at end of cycle
//   HALT    | terminal until resetN
module instruction_sequencer
  import puc_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      run,
  output logic [PC_WIDTH-1:0]       instrAddr,
  input  logic [INSTR_WIDTH-1:0]    instrData,
  output logic [OPCODE_WIDTH-1:0]   opCode,
  output logic [REGISTER_WIDTH-1:0] register1Value,
  output logic [REGISTER_WIDTH-1:0] register2Value,
  output logic [REGISTER_WIDTH-1:0] instructionValue,
  input  logic [REGISTER_WIDTH-1:0] aluResult,
  output logic                      regWrite,
  output logic [REGISTER_WIDTH-1:0] r0Value,
  output logic                      halted
);

  seq_state_t                state;
  logic [PC_WIDTH-1:0]       pc;
  instr_t                    ir;
  reg_addr_t                 read_addr_a;
  reg_addr_t                 read_addr_b;
  data_t                     read_data_a;
  data_t                     read_data_b;

  assign instrAddr = pc;

  // Operands are captured while the new word is still on instrData, so the
  // read ports look at the ROM output during DECODE and at ir otherwise
  always_comb begin
    read_addr_a = field_rd(ir);
    read_addr_b = field_rs(ir);
    if (state == DECODE) begin
      read_addr_a = field_rd(instrData);
      read_addr_b = field_rs(instrData);
    end
  end

  register_file u_regs (
    .clock       (clock),
    .reset_n     (resetN),
    .write_en    (regWrite),
    .write_addr  (field_rd(ir)),
    .write_data  (aluResult),
    .read_addr_a (read_addr_a),
    .read_data_a (read_data_a),
    .read_addr_b (read_addr_b),
    .read_data_b (read_data_b),
    .r0          (r0Value)
  );

  // Sequencer FSM with registered ALU-facing outputs
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state            <= FETCH;
      pc               <= '0;
      ir               <= '0;
      opCode           <= OP_NOP;
      register1Value   <= '0;
      register2Value   <= '0;
      instructionValue <= '0;
      regWrite         <= 1'b0;
      halted           <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (run) state <= DECODE;
        end
        DECODE: begin
          ir               <= instrData;
          opCode           <= field_op(instrData);
          register1Value   <= read_data_a;
          register2Value   <= read_data_b;
          instructionValue <= field_imm(instrData);
          regWrite         <= is_write_op(field_op(instrData));
          state            <= EXECUTE;
        end
        EXECUTE: begin
          opCode           <= OP_NOP;
          register1Value   <= '0;
          register2Value   <= '0;
          instructionValue <= '0;
          regWrite         <= 1'b0;
          if (field_op(ir) == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            if (field_op(ir) == OP_JUMP) pc <= field_imm(ir);
            else                         pc <= pc + PC_WIDTH'(1);
            state <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer with a behavioural ALU and a 1-cycle ROM.
// An instruction-level model predicts every visible EXECUTE; a monitor pops
// the predictions and compares them with what the sequencer presents.
module tb_instruction_sequencer;
  import puc_pkg::*;

  logic        clock = 1'b0;
  logic        resetN;
  logic        run;
  logic [7:0]  instrAddr;
  logic [15:0] instrData;
  logic [3:0]  opCode;
  logic [7:0]  register1Value, register2Value, instructionValue;
  logic [7:0]  aluResult;
  logic        regWrite;
  logic [7:0]  r0Value;
  logic        halted;

  logic [15:0] rom [256];
  logic [7:0]  switches;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] op;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] imm;
    logic       wr;
    logic [7:0] r0_after;
  } exp_t;

  exp_t exp_q [$];
  exp_t got_exp;
  bit   mon_en = 1'b0;
  bit   r0_pending = 1'b0;
  logic [7:0] r0_exp;
  int   wr_seen = 0;

  always #5 clock = ~clock;

  instruction_sequencer dut (
    .clock            (clock),
    .resetN           (resetN),
    .run              (run),
    .instrAddr        (instrAddr),
    .instrData        (instrData),
    .opCode           (opCode),
    .register1Value   (register1Value),
    .register2Value   (register2Value),
    .instructionValue (instructionValue),
    .aluResult        (aluResult),
    .regWrite         (regWrite),
    .r0Value          (r0Value),
    .halted           (halted)
  );

  always @(posedge clock) instrData <= rom[instrAddr];

  always_comb begin
    case (opCode)
      OP_LOAD:       aluResult = instructionValue;
      OP_LOADSWITCH: aluResult = switches;
      OP_ADD:        aluResult = register1Value + register2Value;
      OP_LSHIFT:     aluResult = {register1Value[6:0], 1'b0};
      OP_RSHIFT:     aluResult = {register1Value[7], register1Value[7:1]};
      OP_INC:        aluResult = register1Value + 8'd1;
      OP_DECREMENT:  aluResult = register1Value - 8'd1;
      default:       aluResult = 8'd0;
    endcase
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Monitor: every EXECUTE with a non-zero opcode must match the next prediction
  always @(negedge clock) begin
    if (r0_pending) begin
      check("r0Value after write", 16'(r0Value), 16'(r0_exp));
      r0_pending = 1'b0;
    end
    if (mon_en && resetN) begin
      if (regWrite) wr_seen++;
      if (opCode != 4'd0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected execute: got op %0h at pc %0h, expected none", opCode, instrAddr);
        end else begin
          got_exp = exp_q.pop_front();
          check("exec pc",       16'(instrAddr),        16'(got_exp.pc));
          check("exec opCode",   16'(opCode),           16'(got_exp.op));
          check("exec reg1",     16'(register1Value),   16'(got_exp.r1));
          check("exec reg2",     16'(register2Value),   16'(got_exp.r2));
          check("exec imm",      16'(instructionValue), 16'(got_exp.imm));
          check("exec regWrite", 16'(regWrite),         16'(got_exp.wr));
          if (got_exp.wr) begin
            r0_pending = 1'b1;
            r0_exp     = got_exp.r0_after;
          end
        end
      end else begin
        check("regWrite while idle", 16'(regWrite), 16'd0);
      end
    end
  end

  // Instruction-level reference: walks the ROM with plain integer arithmetic
  task automatic build_model(input int max_steps, output bit halts, output logic [7:0] halt_pc,
                             output int n_instr, output int n_wr);
    int regs [4];
    int pc;
    int a, b, res;
    exp_t rec;
    logic [15:0] w;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    for (int i = 0; i < 4; i++) regs[i] = 0;
    pc = 0; halts = 0; halt_pc = 8'd0; n_instr = 0; n_wr = 0;
    for (int k = 0; k < max_steps; k++) begin
      w = rom[pc];
      op = w[15:12]; rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
      a = regs[rd]; b = regs[rs];
      rec.pc = 8'(pc); rec.op = op; rec.r1 = 8'(a); rec.r2 = 8'(b); rec.imm = imm;
      rec.wr = (op >= 4'd1 && op <= 4'd7);
      n_instr++;
      res = 0;
      case (op)
        4'd1: res = int'(imm);
        4'd2: res = int'(switches);
        4'd3: res = (a + b) % 256;
        4'd4: res = (a * 2) % 256;
        4'd5: res = a / 2 + ((a >= 128) ? 128 : 0);
        4'd6: res = (a + 1) % 256;
        4'd7: res = (a + 255) % 256;
        default: res = 0;
      endcase
      if (rec.wr) begin
        regs[rd] = res;
        n_wr++;
      end
      rec.r0_after = 8'(regs[0]);
      if (op != 4'd0) exp_q.push_back(rec);
      if (op == 4'd15) begin
        halts = 1;
        halt_pc = 8'(pc);
        break;
      end else if (op == 4'd8) begin
        pc = int'(imm);
      end else begin
        pc = (pc + 1) % 256;
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic run_program(input int max_steps, input int stall, input bit rand_run, input bit do_reset);
    bit halts;
    logic [7:0] halt_pc;
    int n_instr, n_wr, cycles, bound;
    if (do_reset) begin
      resetN = 1'b0;
      run    = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset instrAddr", 16'(instrAddr), 16'd0);
      check("reset halted",    16'(halted),    16'd0);
      check("reset r0Value",   16'(r0Value),   16'd0);
      check("reset regWrite",  16'(regWrite),  16'd0);
      check("reset opCode",    16'(opCode),    16'd0);
    end
    exp_q.delete();
    wr_seen = 0;
    build_model(max_steps, halts, halt_pc, n_instr, n_wr);
    mon_en = 1'b1;
    @(negedge clock);
    resetN = 1'b1;
    run    = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock);
      #1;
      check("stall instrAddr", 16'(instrAddr), 16'd0);
      check("stall opCode",    16'(opCode),    16'd0);
      check("stall r0Value",   16'(r0Value),   16'd0);
    end
    run = 1'b1;
    if (halts) begin
      cycles = 0;
      bound  = 3 * n_instr * (rand_run ? 8 : 1) + 20;
      while (!halted && cycles < bound) begin
        @(posedge clock);
        #1;
        cycles++;
        if (rand_run) run = ($urandom_range(0, 9) < 7);
      end
      check("halted reached", 16'(halted), 16'd1);
      if (!rand_run) check("cycles to halt", 16'(cycles), 16'(3 * n_instr));
      repeat (3) @(negedge clock);
      #1;
      check("halt pc holds",     16'(instrAddr), 16'(halt_pc));
      check("halted holds",      16'(halted),    16'd1);
      check("halt opCode",       16'(opCode),    16'd0);
    end else begin
      repeat (3 * max_steps) @(negedge clock);
      #1;
    end
    check("pending predictions", 16'(exp_q.size()), 16'd0);
    check("regWrite pulses",     16'(wr_seen),      16'(n_wr));
    mon_en = 1'b0;
  endtask

  initial begin
    int len;
    logic [3:0] op;
    resetN   = 1'b0;
    run      = 1'b0;
    switches = 8'h3C;
    clear_rom();

    // LOAD R1,#5A; ADD R1,R1; HALT
    rom[0] = ins(OP_LOAD, 2'd1, 2'd0, 8'h5A);
    rom[1] = ins(OP_ADD,  2'd1, 2'd1, 8'h00);
    rom[2] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    run_program(10, 0, 0, 1);

    // r0 wrap via INC, shift left of zero, arithmetic shift right
    clear_rom();
    rom[0] = ins(OP_LOAD,   2'd0, 2'd0, 8'hFF);
    rom[1] = ins(OP_INC,    2'd0, 2'd0, 8'h00);
    rom[2] = ins(OP_LSHIFT, 2'd0, 2'd0, 8'h00);
    rom[3] = ins(OP_LOAD,   2'd0, 2'd0, 8'h81);
    rom[4] = ins(OP_RSHIFT, 2'd0, 2'd0, 8'h00);
    rom[5] = ins(OP_DECREMENT, 2'd0, 2'd0, 8'h00);
    rom[6] = ins(OP_HALT,   2'd0, 2'd0, 8'h00);
    run_program(20, 0, 0, 1);

    // JUMP to 0x10 which holds HALT
    clear_rom();
    rom[0]     = ins(OP_JUMP, 2'd0, 2'd0, 8'h10);
    rom[8'h10] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    run_program(10, 0, 0, 1);

    // pc wrap FF -> 00 (program loops; bounded by step count)
    clear_rom();
    rom[0]     = ins(OP_JUMP, 2'd0, 2'd0, 8'hFE);
    rom[8'hFE] = ins(OP_LOAD, 2'd1, 2'd0, 8'h44);
    rom[8'hFF] = ins(OP_INC,  2'd1, 2'd0, 8'h00);
    run_program(7, 0, 0, 1);

    // run held low for 5 cycles after reset, then the first program again
    clear_rom();
    rom[0] = ins(OP_LOAD, 2'd1, 2'd0, 8'h5A);
    rom[1] = ins(OP_ADD,  2'd1, 2'd1, 8'h00);
    rom[2] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    run_program(10, 5, 0, 1);

    // reset during EXECUTE of LOAD R2,#33 must discard the write
    clear_rom();
    rom[0] = ins(OP_LOAD, 2'd2, 2'd0, 8'h33);
    resetN = 1'b0;
    run    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    run    = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("abort pre opCode",   16'(opCode),   16'(OP_LOAD));
    check("abort pre regWrite", 16'(regWrite), 16'd1);
    resetN = 1'b0;
    @(posedge clock);
    #1;
    check("abort instrAddr", 16'(instrAddr), 16'd0);
    check("abort regWrite",  16'(regWrite),  16'd0);
    check("abort opCode",    16'(opCode),    16'd0);
    clear_rom();
    rom[0] = ins(OP_ADD,  2'd0, 2'd2, 8'h00);
    rom[1] = ins(OP_INC,  2'd2, 2'd0, 8'h00);
    rom[2] = ins(OP_ADD,  2'd0, 2'd2, 8'h00);
    rom[3] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    run_program(10, 0, 0, 0);

    // randomized straight-line programs with random run gaps
    for (int p = 0; p < 8; p++) begin
      clear_rom();
      switches = 8'($urandom);
      len = $urandom_range(4, 20);
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(0, 13));
        if (op > 4'd7) op = op + 4'd1;
        rom[i] = ins(op, 2'($urandom), 2'($urandom), 8'($urandom));
      end
      rom[len] = ins(OP_HALT, 2'($urandom), 2'($urandom), 8'($urandom));
      run_program(len + 1, 0, (p % 2) == 1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
